load_forward_unit: RTL and testbench
====================================

Name: load_forward_unit

Overview:
- Load-side reader of the store buffer.
- Accepts one load at a time. Snapshots the buffered stores and forwards the youngest store whose address matches the load; otherwise reads data memory over a fixed-latency read port.
- Snoops the store-buffer drain port so a store written to memory during an in-flight read is not lost.
- Sits between the load issue stage and data memory, alongside the store buffer.

Parameters:
- DEPTH, 16, store-buffer entries searched; power of two, pointer width PW = log2(DEPTH).
- MEM_LAT, 2, cycles from mem_ren to valid mem_rdata; minimum 1.
- TAG_W, 4, width of the load tag carried through to the result.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ld_valid  in  1  load request valid.
- ld_ready  out  1  unit can accept a load.
- ld_addr  in  16  load byte address.
- ld_tag  in  TAG_W  load identifier.
- sb_addresses_flat  in  16*DEPTH  entry i occupies bits [16i+15:16i].
- sb_values_flat  in  8*DEPTH  entry i occupies bits [8i+7:8i].
- sb_valid_flat  in  DEPTH  entry i holds a store not yet drained.
- sb_head  in  PW  next write slot; entry head-1 is the youngest store.
- sb_wen  in  1  store-buffer drain write, one cycle.
- sb_waddr  in  16  drain address.
- sb_wdata  in  8  drain data.
- mem_ren  out  1  memory read strobe, one cycle.
- mem_raddr  out  16  memory read address.
- mem_rdata  in  8  memory data, valid exactly MEM_LAT cycles after mem_ren.
- res_valid  out  1  load result valid.
- res_ready  in  1  consumer accepts the result.
- res_tag  out  TAG_W  tag of the returned load.
- res_data  out  8  loaded byte.
- res_fwd  out  1  1 = data was forwarded from the store buffer.
- stat_fwd_cnt  out  16  forward counter (see Optional Feature).
- stat_mem_cnt  out  16  memory-load counter (see Optional Feature).

Behaviour:
- Reset values (rst_n low): state IDLE, ld_ready=1, mem_ren=0, mem_raddr=0, res_valid=0, res_tag=0, res_data=0, res_fwd=0, counters=0.
- Reset takes effect immediately, including mid-operation; any in-flight load is dropped, and a mem_rdata arriving afterwards is ignored.
- States: IDLE, SEARCH, WAIT_MEM, RESP.
- IDLE: ld_ready=1. When ld_valid is high at a clock edge, register ld_addr and ld_tag, then go to SEARCH. ld_ready=0 in every other state.
- SEARCH (one cycle): compare the registered address against every entry with sb_valid_flat[i]=1.
  - Age of entry i = (sb_head-1-i) mod DEPTH; on multiple matches the smallest age wins.
  - Hit: res_data = matching value, res_fwd=1, go to RESP.
  - Miss: mem_ren=1 and mem_raddr=address for one cycle, load counter with MEM_LAT, go to WAIT_MEM.
- WAIT_MEM: counter decrements each cycle. When the count reaches 0, capture mem_rdata, set res_fwd=0, go to RESP.
- Drain snoop: in SEARCH-miss and WAIT_MEM cycles, if sb_wen=1 and sb_waddr equals the load address, latch sb_wdata into an override register.
  - On capture, the override replaces mem_rdata; the latest snooped write wins.
  - res_fwd stays 0.
  - The override clears on entry to SEARCH.
- RESP: res_valid=1; res_tag, res_data, res_fwd are held stable until res_ready=1. At that edge: res_valid goes to 0 and the state returns to IDLE. A new load is accepted the following cycle, never in the same cycle.
- Latency, ld accepted at cycle 0:
  - Forward hit: res_valid at cycle 2.
  - Memory path: mem_ren at cycle 1, res_valid at cycle 2+MEM_LAT.
- Boundary cases:
  - Empty buffer (all valid bits 0): always a miss.
  - sb_head=0: youngest entry is DEPTH-1; the age comparison wraps.
  - A store is drained during SEARCH and its valid bit is already 0: the snoop still catches it.
  - Address compare is exact on all 16 bits.

Optional Feature:
- Macro: LOAD_FWD_STATS_EN.
- Defined:
  - stat_fwd_cnt increments on each SEARCH hit.
  - stat_mem_cnt increments on each mem_ren.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- Empty buffer, ld_addr=16'h0040, tag 3, MEM_LAT=2, mem_rdata=8'hA5 → mem_ren at cycle 1 with addr 16'h0040; res_valid at cycle 4, data A5, tag 3, fwd 0.
- Entries 2 and 5 valid, both addr 16'h0100 with values 11/22, sb_head=6 → cycle-2 result 8'h22, fwd 1, no mem_ren.
- Wrap: sb_head=0, entries 15 and 1 match with values 33/44 → result 33, since entry 15 is youngest.
- Miss on 16'h0200, then sb_wen addr 16'h0200 data 8'h5A during WAIT_MEM, mem_rdata 8'h00 → result 5A, fwd 0.
- res_ready held low 3 cycles in RESP → outputs stable and ld_ready=0; after res_ready, IDLE and ld_ready=1 the next cycle.
- rst_n low during WAIT_MEM → immediate IDLE and res_valid=0; the late mem_rdata produces no result. Stats build: counters match the hit/miss counts, and saturation is checked by forcing 16'hFFFE.

Source files
------------

// File: rtl/load_forward_unit_if.sv
// Bus bundle for load_forward_unit: load issue, store-buffer snapshot and
// drain snoop, data-memory read port, result handshake and statistics.
// slave  = the forwarding unit, master = the surrounding pipeline/memory.
interface load_forward_unit_if #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
);
  localparam int PW = $clog2(DEPTH);

  logic                   ld_valid;
  logic                   ld_ready;
  logic [15:0]            ld_addr;
  logic [TAG_W-1:0]       ld_tag;

  logic [16*DEPTH-1:0]    sb_addresses_flat;
  logic [8*DEPTH-1:0]     sb_values_flat;
  logic [DEPTH-1:0]       sb_valid_flat;
  logic [PW-1:0]          sb_head;
  logic                   sb_wen;
  logic [15:0]            sb_waddr;
  logic [7:0]             sb_wdata;

  logic                   mem_ren;
  logic [15:0]            mem_raddr;
  logic [7:0]             mem_rdata;

  logic                   res_valid;
  logic                   res_ready;
  logic [TAG_W-1:0]       res_tag;
  logic [7:0]             res_data;
  logic                   res_fwd;

  logic [15:0]            stat_fwd_cnt;
  logic [15:0]            stat_mem_cnt;

  modport slave (
    input  ld_valid, ld_addr, ld_tag,
    input  sb_addresses_flat, sb_values_flat, sb_valid_flat, sb_head,
    input  sb_wen, sb_waddr, sb_wdata,
    input  mem_rdata, res_ready,
    output ld_ready, mem_ren, mem_raddr,
    output res_valid, res_tag, res_data, res_fwd,
    output stat_fwd_cnt, stat_mem_cnt
  );

  modport master (
    output ld_valid, ld_addr, ld_tag,
    output sb_addresses_flat, sb_values_flat, sb_valid_flat, sb_head,
    output sb_wen, sb_waddr, sb_wdata,
    output mem_rdata, res_ready,
    input  ld_ready, mem_ren, mem_raddr,
    input  res_valid, res_tag, res_data, res_fwd,
    input  stat_fwd_cnt, stat_mem_cnt
  );
endinterface

// File: rtl/load_forward_unit.sv
// load_forward_unit: services one load at a time. The youngest matching
// store-buffer entry is forwarded; otherwise data memory is read over a
// fixed-latency port while drain writes to the same address are snooped so
// a store leaving the buffer mid-read still supplies the load's data.
// Optional macro LOAD_FWD_STATS_EN adds saturating hit/miss counters;
// without it the stat outputs are tied to zero.
module load_forward_unit #(
  parameter int DEPTH   = 16,
  parameter int MEM_LAT = 2,
  parameter int TAG_W   = 4
) (
  input logic               clk,
  input logic               rst_n,
  load_forward_unit_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, SEARCH, WAIT_MEM, RESP} state_t;

  state_t           state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovr_vld_q, ovr_vld_d;
  logic [7:0]       ovr_data_q, ovr_data_d;
  logic [7:0]       res_data_q, res_data_d;
  logic             res_fwd_q, res_fwd_d;
  logic             mem_ren;

  // Per-entry unpack and address match against the registered load address.
  logic [15:0]      ent_addr [DEPTH];
  logic [7:0]       ent_val  [DEPTH];
  logic [DEPTH-1:0] ent_match;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign ent_addr[gi]  = bus.sb_addresses_flat[16*gi +: 16];
    assign ent_val[gi]   = bus.sb_values_flat[8*gi +: 8];
    assign ent_match[gi] = bus.sb_valid_flat[gi] && (ent_addr[gi] == addr_q);
  end

  // Youngest-match select: walk from oldest (age DEPTH-1) to youngest (age 0)
  // so the last assignment is the smallest age. Pointer math wraps mod DEPTH.
  logic       hit;
  logic [7:0] hit_data;
  always_comb begin
    logic [PW-1:0] idx;
    hit      = 1'b0;
    hit_data = 8'h00;
    idx      = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = bus.sb_head - PW'(k + 1);
      if (ent_match[idx]) begin
        hit      = 1'b1;
        hit_data = ent_val[idx];
      end
    end
  end

  // A drain write to the load's address seen while the memory read is open.
  logic snoop_hit;
  logic snoop_window;
  assign snoop_hit    = bus.sb_wen && (bus.sb_waddr == addr_q);
  assign snoop_window = ((state_q == SEARCH) && !hit) || (state_q == WAIT_MEM);

  // Next-state and datapath updates for the load FSM.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    ovr_vld_d  = ovr_vld_q;
    ovr_data_d = ovr_data_q;
    res_data_d = res_data_q;
    res_fwd_d  = res_fwd_q;
    mem_ren    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ld_valid) begin
          addr_d    = bus.ld_addr;
          tag_d     = bus.ld_tag;
          ovr_vld_d = 1'b0;
          state_d   = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          res_data_d = hit_data;
          res_fwd_d  = 1'b1;
          state_d    = RESP;
        end else begin
          mem_ren = 1'b1;
          // The final WAIT_MEM cycle is the one with count 0, which lines up
          // with mem_rdata arriving MEM_LAT cycles after mem_ren.
          cnt_d   = CW'(MEM_LAT - 1);
          state_d = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (cnt_q == '0) begin
          // A drain in this very cycle is newer than anything latched earlier.
          if (snoop_hit)      res_data_d = bus.sb_wdata;
          else if (ovr_vld_q) res_data_d = ovr_data_q;
          else                res_data_d = bus.mem_rdata;
          res_fwd_d = 1'b0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (snoop_window && snoop_hit) begin
      ovr_vld_d  = 1'b1;
      ovr_data_d = bus.sb_wdata;
    end
  end

  // State and datapath registers; reset drops any in-flight load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      tag_q      <= '0;
      cnt_q      <= '0;
      ovr_vld_q  <= 1'b0;
      ovr_data_q <= '0;
      res_data_q <= '0;
      res_fwd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      ovr_vld_q  <= ovr_vld_d;
      ovr_data_q <= ovr_data_d;
      res_data_q <= res_data_d;
      res_fwd_q  <= res_fwd_d;
    end
  end

  assign bus.ld_ready  = (state_q == IDLE);
  assign bus.mem_ren   = mem_ren;
  assign bus.mem_raddr = addr_q;
  assign bus.res_valid = (state_q == RESP);
  assign bus.res_tag   = tag_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_fwd   = res_fwd_q;

`ifdef LOAD_FWD_STATS_EN
  logic [15:0] fwd_cnt_q, fwd_cnt_d;
  logic [15:0] mem_cnt_q, mem_cnt_d;

  // Saturating increments for forward hits and memory reads.
  always_comb begin
    fwd_cnt_d = fwd_cnt_q;
    mem_cnt_d = mem_cnt_q;
    if ((state_q == SEARCH) && hit && (fwd_cnt_q != 16'hFFFF)) fwd_cnt_d = fwd_cnt_q + 16'd1;
    if (mem_ren && (mem_cnt_q != 16'hFFFF))                    mem_cnt_d = mem_cnt_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q <= '0;
      mem_cnt_q <= '0;
    end else begin
      fwd_cnt_q <= fwd_cnt_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

  assign bus.stat_fwd_cnt = fwd_cnt_q;
  assign bus.stat_mem_cnt = mem_cnt_q;
`else
  assign bus.stat_fwd_cnt = 16'h0000;
  assign bus.stat_mem_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_load_forward_unit.sv
// Bench for load_forward_unit: directed vector table, randomized loads
// against a reference model, and hand sequences for stall and reset.
module tb_load_forward_unit;
  localparam int DEPTH   = 16;
  localparam int MEM_LAT = 2;
  localparam int TAG_W   = 4;
  localparam int PW      = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_forward_unit_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  load_forward_unit #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- store buffer image ----------------
  logic [15:0]      sb_a [DEPTH];
  logic [7:0]       sb_v [DEPTH];
  logic [DEPTH-1:0] sb_vld;
  logic [PW-1:0]    sb_hd;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pack
    assign bus.sb_addresses_flat[16*gi +: 16] = sb_a[gi];
    assign bus.sb_values_flat[8*gi +: 8]      = sb_v[gi];
  end
  assign bus.sb_valid_flat = sb_vld;
  assign bus.sb_head       = sb_hd;

  // ---------------- memory model ----------------
  logic [7:0] mem_img [logic [15:0]];

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  logic        pipe_v [MEM_LAT];
  logic [15:0] pipe_a [MEM_LAT];
  logic [7:0]  garbage = 8'h00;

  always @(posedge clk) begin
    pipe_v[0] <= bus.mem_ren;
    pipe_a[0] <= bus.mem_raddr;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
    garbage <= 8'($urandom);
  end

  always_comb begin
    bus.mem_rdata = garbage;
    if (pipe_v[MEM_LAT-1] === 1'b1) bus.mem_rdata = mem_byte(pipe_a[MEM_LAT-1]);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drain schedule, indexed by cycle relative to load acceptance.
  logic        dr_en [16];
  logic [15:0] dr_a  [16];
  logic [7:0]  dr_d  [16];

  task automatic clear_drains();
    for (int i = 0; i < 16; i++) begin
      dr_en[i] = 1'b0;
      dr_a[i]  = 16'h0000;
      dr_d[i]  = 8'h00;
    end
  endtask

  // Issue one load, follow it to the result handshake and check everything.
  task automatic run_load(input logic [15:0] addr, input logic [TAG_W-1:0] tag,
                          input int ready_delay, input logic [7:0] exp_data,
                          input logic exp_fwd, input string nm);
    int res_cycle, ren_cnt, ren_cycle, held;
    logic done, unstable, busy;
    logic [15:0] ren_addr;
    logic [7:0] d0;
    logic f0;
    logic [TAG_W-1:0] t0;
    res_cycle = -1; ren_cnt = 0; ren_cycle = -1; held = 0;
    done = 1'b0; unstable = 1'b0; busy = 1'b0;
    ren_addr = 16'h0; d0 = 8'h0; f0 = 1'b0; t0 = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      bus.ld_valid  = (c == 0) || (res_cycle >= 0);
      bus.ld_addr   = (c == 0) ? addr : 16'($urandom);
      bus.ld_tag    = (c == 0) ? tag : TAG_W'($urandom);
      bus.sb_wen    = (c < 16) ? dr_en[c] : 1'b0;
      bus.sb_waddr  = (c < 16) ? dr_a[c] : 16'h0;
      bus.sb_wdata  = (c < 16) ? dr_d[c] : 8'h0;
      bus.res_ready = 1'b0;
      #1;
      if (c == 0) check({nm, " ld_ready at issue"}, 32'(bus.ld_ready), 32'd1);
      if (bus.mem_ren) begin
        ren_cnt++;
        ren_cycle = c;
        ren_addr  = bus.mem_raddr;
      end
      if (bus.res_valid) begin
        if (res_cycle < 0) begin
          res_cycle = c;
          d0 = bus.res_data; f0 = bus.res_fwd; t0 = bus.res_tag;
        end else if (bus.res_data !== d0 || bus.res_fwd !== f0 || bus.res_tag !== t0) begin
          unstable = 1'b1;
        end
        if (bus.ld_ready) busy = 1'b1;
        if (held >= ready_delay) begin
          bus.res_ready = 1'b1;
          done = 1'b1;
        end
        held++;
      end
    end
    check({nm, " latency"}, 32'(res_cycle), exp_fwd ? 32'd2 : 32'(2 + MEM_LAT));
    check({nm, " data"}, 32'(d0), 32'(exp_data));
    check({nm, " fwd"}, 32'(f0), 32'(exp_fwd));
    check({nm, " tag"}, 32'(t0), 32'(tag));
    check({nm, " mem_ren count"}, 32'(ren_cnt), exp_fwd ? 32'd0 : 32'd1);
    if (!exp_fwd) begin
      check({nm, " mem_ren cycle"}, 32'(ren_cycle), 32'd1);
      check({nm, " mem_raddr"}, 32'(ren_addr), 32'(addr));
    end
    if (ready_delay > 0) begin
      check({nm, " held stable"}, 32'(unstable), 32'd0);
      check({nm, " ld_ready low in RESP"}, 32'(busy), 32'd0);
    end
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.sb_wen = 1'b0;
    bus.res_ready = 1'b0;
    #1;
    check({nm, " idle ld_ready"}, 32'(bus.ld_ready), 32'd1);
    check({nm, " idle res_valid"}, 32'(bus.res_valid), 32'd0);
    if (exp_fwd) exp_hits++; else exp_miss++;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string            name;
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    head;
    int               ea;
    logic [15:0]      aa;
    logic [7:0]       va;
    int               eb;
    logic [15:0]      ab;
    logic [7:0]       vb;
    logic [15:0]      ld_addr;
    logic [TAG_W-1:0] tag;
    int               dr_cyc;
    logic [15:0]      dr_addr;
    logic [7:0]       dr_data;
    int               rdy;
    logic [7:0]       exp_data;
    logic             exp_fwd;
  } vec_t;

  vec_t vecs [9];

  task automatic load_vec_sb(input vec_t v);
    for (int i = 0; i < DEPTH; i++) begin
      sb_a[i] = 16'hF000 + 16'(i);
      sb_v[i] = 8'hEE;
    end
    sb_a[v.ea] = v.aa; sb_v[v.ea] = v.va;
    sb_a[v.eb] = v.ab; sb_v[v.eb] = v.vb;
    sb_vld = v.vld;
    sb_hd  = v.head;
    clear_drains();
    if (v.dr_cyc >= 0) begin
      dr_en[v.dr_cyc] = 1'b1;
      dr_a[v.dr_cyc]  = v.dr_addr;
      dr_d[v.dr_cyc]  = v.dr_data;
    end
  endtask

  task automatic run_vec(input vec_t v);
    load_vec_sb(v);
    run_load(v.ld_addr, v.tag, v.rdy, v.exp_data, v.exp_fwd, v.name);
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0] rexp;
    logic rfwd;
    int age_idx;

    bus.ld_valid = 1'b0; bus.ld_addr = 16'h0; bus.ld_tag = '0;
    bus.sb_wen = 1'b0; bus.sb_waddr = 16'h0; bus.sb_wdata = 8'h0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < MEM_LAT; i++) begin pipe_v[i] = 1'b0; pipe_a[i] = 16'h0; end
    for (int i = 0; i < DEPTH; i++) begin sb_a[i] = 16'h0; sb_v[i] = 8'h0; end
    sb_vld = '0; sb_hd = '0;
    clear_drains();

    mem_img[16'h0040] = 8'hA5;
    mem_img[16'h0200] = 8'h00;
    mem_img[16'h0100] = 8'hC3;
    mem_img[16'h0300] = 8'h12;
    mem_img[16'h0400] = 8'h21;
    mem_img[16'h0500] = 8'h44;
    mem_img[16'h0600] = 8'h7E;

    //            name         vld                head ea aa       va     eb ab       vb     ld_addr  tag dcyc daddr    ddata  rdy exp    fwd
    vecs[0] = '{"empty",      16'h0000,           4'd0, 0, 16'h0000, 8'h00, 1, 16'h0000, 8'h00, 16'h0040, 4'd3, -1, 16'h0000, 8'h00, 0, 8'hA5, 1'b0};
    vecs[1] = '{"youngest",   16'h0024,           4'd6, 2, 16'h0100, 8'h11, 5, 16'h0100, 8'h22, 16'h0100, 4'd5, -1, 16'h0000, 8'h00, 0, 8'h22, 1'b1};
    vecs[2] = '{"wrap",       16'h8002,           4'd0, 15, 16'h0100, 8'h33, 1, 16'h0100, 8'h44, 16'h0100, 4'd9, -1, 16'h0000, 8'h00, 0, 8'h33, 1'b1};
    vecs[3] = '{"snoop_wait", 16'h0000,           4'd0, 0, 16'h0000, 8'h00, 1, 16'h0000, 8'h00, 16'h0200, 4'd1, 2, 16'h0200, 8'h5A, 0, 8'h5A, 1'b0};
    vecs[4] = '{"stall",      16'h0024,           4'd6, 2, 16'h0100, 8'h11, 5, 16'h0100, 8'h22, 16'h0100, 4'd7, -1, 16'h0000, 8'h00, 3, 8'h22, 1'b1};
    vecs[5] = '{"exact_cmp",  16'h0018,           4'd5, 3, 16'h0101, 8'h66, 4, 16'h8100, 8'h77, 16'h0100, 4'd2, -1, 16'h0000, 8'h00, 0, 8'hC3, 1'b0};
    vecs[6] = '{"snoop_srch", 16'h0000,           4'd3, 2, 16'h0300, 8'h55, 1, 16'h0000, 8'h00, 16'h0300, 4'd4, 1, 16'h0300, 8'h9D, 0, 8'h9D, 1'b0};
    vecs[7] = '{"snoop_idle", 16'h0000,           4'd0, 0, 16'h0000, 8'h00, 1, 16'h0000, 8'h00, 16'h0400, 4'd6, 0, 16'h0400, 8'h55, 1, 8'h21, 1'b0};
    vecs[8] = '{"snoop_last", 16'h0000,           4'd0, 0, 16'h0000, 8'h00, 1, 16'h0000, 8'h00, 16'h0500, 4'd8, 1 + MEM_LAT, 16'h0500, 8'h6B, 0, 8'h6B, 1'b0};

    // Reset state
    #1;
    check("reset ld_ready", 32'(bus.ld_ready), 32'd1);
    check("reset mem_ren", 32'(bus.mem_ren), 32'd0);
    check("reset mem_raddr", 32'(bus.mem_raddr), 32'd0);
    check("reset res_valid", 32'(bus.res_valid), 32'd0);
    check("reset res_tag", 32'(bus.res_tag), 32'd0);
    check("reset res_data", 32'(bus.res_data), 32'd0);
    check("reset res_fwd", 32'(bus.res_fwd), 32'd0);
    check("reset stat_fwd", 32'(bus.stat_fwd_cnt), 32'd0);
    check("reset stat_mem", 32'(bus.stat_mem_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 9; k++) run_vec(vecs[k]);

    // Randomized loads against the reference model
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb_a[i] = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h1000 + 16'($urandom_range(0, 7));
        if ($urandom_range(0, 9) == 0) sb_a[i] = sb_a[i] ^ 16'h8000;
        sb_v[i] = 8'($urandom);
      end
      sb_vld = ($urandom_range(0, 4) == 0) ? '0 : DEPTH'($urandom) & DEPTH'($urandom);
      sb_hd  = PW'($urandom);
      ra = 16'h1000 + 16'($urandom_range(0, 7));
      for (int c = 0; c < 16; c++) begin
        dr_en[c] = ($urandom_range(0, 2) == 0);
        dr_a[c]  = ($urandom_range(0, 1) == 0) ? ra : 16'h1000 + 16'($urandom_range(0, 7));
        dr_d[c]  = 8'($urandom);
      end
      // Reference: smallest-age valid match forwards; otherwise memory,
      // overridden by the last matching drain while the read is open.
      rfwd = 1'b0;
      rexp = 8'h00;
      for (int age = 0; age < DEPTH; age++) begin
        age_idx = (int'(sb_hd) + DEPTH - 1 - age) % DEPTH;
        if (!rfwd && sb_vld[age_idx] && sb_a[age_idx] == ra) begin
          rfwd = 1'b1;
          rexp = sb_v[age_idx];
        end
      end
      if (!rfwd) begin
        rexp = mem_byte(ra);
        for (int c = 1; c <= 1 + MEM_LAT; c++)
          if (dr_en[c] && dr_a[c] == ra) rexp = dr_d[c];
      end
      run_load(ra, TAG_W'($urandom), $urandom_range(0, 3), rexp, rfwd, $sformatf("rand%0d", n));
    end

    // Counters before reset
`ifdef LOAD_FWD_STATS_EN
    check("stat_fwd_cnt", 32'(bus.stat_fwd_cnt), 32'(exp_hits));
    check("stat_mem_cnt", 32'(bus.stat_mem_cnt), 32'(exp_miss));
`else
    check("stat_fwd_cnt off", 32'(bus.stat_fwd_cnt), 32'd0);
    check("stat_mem_cnt off", 32'(bus.stat_mem_cnt), 32'd0);
`endif

    // Reset during WAIT_MEM; the late memory data must not produce a result
    sb_vld = '0;
    clear_drains();
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.ld_addr = 16'h0600; bus.ld_tag = 4'd2;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    #1 check("rst seq mem_ren", 32'(bus.mem_ren), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst seq res_valid", 32'(bus.res_valid), 32'd0);
    check("rst seq ld_ready", 32'(bus.ld_ready), 32'd1);
    check("rst seq res_tag", 32'(bus.res_tag), 32'd0);
    check("rst seq stat_fwd", 32'(bus.stat_fwd_cnt), 32'd0);
    check("rst seq stat_mem", 32'(bus.stat_mem_cnt), 32'd0);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("post-rst res_valid c%0d", c), 32'(bus.res_valid), 32'd0);
      check($sformatf("post-rst ld_ready c%0d", c), 32'(bus.ld_ready), 32'd1);
    end
    run_vec(vecs[0]);

`ifdef LOAD_FWD_STATS_EN
    // Saturation
    @(negedge clk);
    force dut.fwd_cnt_q = 16'hFFFE;
    force dut.mem_cnt_q = 16'hFFFE;
    #1;
    release dut.fwd_cnt_q;
    release dut.mem_cnt_q;
    run_vec(vecs[1]);
    run_vec(vecs[1]);
    run_vec(vecs[0]);
    run_vec(vecs[0]);
    check("stat_fwd_cnt saturate", 32'(bus.stat_fwd_cnt), 32'hFFFF);
    check("stat_mem_cnt saturate", 32'(bus.stat_mem_cnt), 32'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
